// File: rtl/shift_restore.sv
// shift_restore: undoes an upstream left shift on returning sample pairs.
//
// Every sample pair sent into the datapath was shifted left by a tag. The tag
// is queued here (shift_in/shift_valid). When the processed pair comes back
// (din1/din2/din_valid), the oldest tag is popped. It is clamped to MAX_SHIFT
// and used to shift both words right. Results appear two cycles after
// din_valid.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   shift_in, shift_valid tag push interface
//   din1, din2, din_valid returning data; each din_valid pops one tag
//   dout1, dout2          right-shifted data
//   dout_shift            clamped tag applied to the current dout pair
//   dout_valid            dout1/dout2/dout_shift valid
//   fifo_count            number of tags stored
//   overflow, underflow   sticky error flags, cleared only by reset
//
// Build option: define SHIFT_RESTORE_ROUND_EN to round half up instead of
// truncating.

module shift_restore #(
    parameter int DIN_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5,
    parameter int MAX_SHIFT   = 10,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SHIFT_WIDTH-1:0]       shift_in,
    input  logic                         shift_valid,
    input  logic [DIN_WIDTH-1:0]         din1,
    input  logic [DIN_WIDTH-1:0]         din2,
    input  logic                         din_valid,
    output logic [DIN_WIDTH-1:0]         dout1,
    output logic [DIN_WIDTH-1:0]         dout2,
    output logic [SHIFT_WIDTH-1:0]       dout_shift,
    output logic                         dout_valid,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int                     PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]         FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [SHIFT_WIDTH-1:0] MAX_TAG  = SHIFT_WIDTH'(MAX_SHIFT);

    logic [SHIFT_WIDTH-1:0] tag_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   bypass;
    logic                   do_pop;
    logic                   do_push;
    logic [SHIFT_WIDTH-1:0] sel_tag;
    logic [SHIFT_WIDTH-1:0] clamp_tag;

    logic                   s1_valid;
    logic [DIN_WIDTH-1:0]   s1_din1;
    logic [DIN_WIDTH-1:0]   s1_din2;
    logic [SHIFT_WIDTH-1:0] s1_tag;

    logic [DIN_WIDTH-1:0]   shr1;
    logic [DIN_WIDTH-1:0]   shr2;

    always_comb begin
        fifo_empty = (fifo_count == '0);
        fifo_full  = (fifo_count == FULL_CNT);
        // An empty FIFO with a tag arriving alongside the data forwards the
        // tag straight through, so it never occupies a slot.
        bypass     = fifo_empty && shift_valid && din_valid;
        do_pop     = din_valid && !fifo_empty;
        // A pop in the same cycle frees the slot the push needs.
        do_push    = shift_valid && !bypass && (!fifo_full || do_pop);

        sel_tag = '0;
        if (bypass)
            sel_tag = shift_in;
        else if (do_pop)
            sel_tag = tag_mem[rd_ptr];

        clamp_tag = (sel_tag > MAX_TAG) ? MAX_TAG : sel_tag;
    end

    // Tag storage is not reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push)
            tag_mem[wr_ptr] <= shift_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (shift_valid && fifo_full && !do_pop)
                overflow <= 1'b1;
            if (din_valid && fifo_empty && !shift_valid)
                underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_din1  <= '0;
            s1_din2  <= '0;
            s1_tag   <= '0;
        end else begin
            s1_valid <= din_valid;
            if (din_valid) begin
                s1_din1 <= din1;
                s1_din2 <= din2;
                s1_tag  <= clamp_tag;
            end
        end
    end

`ifdef SHIFT_RESTORE_ROUND_EN
    // One extra bit of headroom so adding the half-LSB never wraps.
    logic [DIN_WIDTH:0] rnd_inc;
    logic [DIN_WIDTH:0] sum1;
    logic [DIN_WIDTH:0] sum2;

    always_comb begin
        rnd_inc = '0;
        if (s1_tag != '0)
            rnd_inc = (DIN_WIDTH+1)'(1) << (s1_tag - 1'b1);
        sum1 = {1'b0, s1_din1} + rnd_inc;
        sum2 = {1'b0, s1_din2} + rnd_inc;
        shr1 = DIN_WIDTH'(sum1 >> s1_tag);
        shr2 = DIN_WIDTH'(sum2 >> s1_tag);
    end
`else
    always_comb begin
        shr1 = s1_din1 >> s1_tag;
        shr2 = s1_din2 >> s1_tag;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            dout1      <= '0;
            dout2      <= '0;
            dout_shift <= '0;
        end else begin
            dout_valid <= s1_valid;
            if (s1_valid) begin
                dout1      <= shr1;
                dout2      <= shr2;
                dout_shift <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_shift_restore.sv
module tb_shift_restore;

    localparam int DW    = 32;
    localparam int SW    = 5;
    localparam int MAXS  = 10;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic [SW-1:0] shift_in;
    logic          shift_valid;
    logic [DW-1:0] din1;
    logic [DW-1:0] din2;
    logic          din_valid;
    logic [DW-1:0] dout1;
    logic [DW-1:0] dout2;
    logic [SW-1:0] dout_shift;
    logic          dout_valid;
    logic [4:0]    fifo_count;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_err = 0;

    shift_restore #(
        .DIN_WIDTH(DW), .SHIFT_WIDTH(SW), .MAX_SHIFT(MAXS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .shift_in(shift_in), .shift_valid(shift_valid),
        .din1(din1), .din2(din2), .din_valid(din_valid),
        .dout1(dout1), .dout2(dout2), .dout_shift(dout_shift), .dout_valid(dout_valid),
        .fifo_count(fifo_count), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a tag queue plus the expected content of the two
    // pipeline stages, computed from plain arithmetic.
    int          q[$];
    bit          m_ovf, m_unf;
    bit          m1_v;
    logic [31:0] m1_d1, m1_d2;
    int          m1_s;
    bit          m2_v;
    logic [31:0] e1, e2;
    int          es;

    function automatic logic [31:0] restore(input logic [31:0] d, input int s);
        longint v;
        v = longint'(d);
`ifdef SHIFT_RESTORE_ROUND_EN
        if (s > 0) v = v + (longint'(1) << (s - 1));
`endif
        return 32'(v >> s);
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_unf = 0;
        m1_v = 0; m1_d1 = '0; m1_d2 = '0; m1_s = 0;
        m2_v = 0; e1 = '0; e2 = '0; es = 0;
    endtask

    task automatic model_update(input bit sv, input int si, input bit dv,
                                input logic [31:0] d1, input logic [31:0] d2);
        bit byp;
        int tag;
        if (m1_v) begin
            e1 = restore(m1_d1, m1_s);
            e2 = restore(m1_d2, m1_s);
            es = m1_s;
        end
        m2_v = m1_v;
        byp = dv && sv && (q.size() == 0);
        m1_v = dv;
        if (dv) begin
            if (q.size() == 0) begin
                if (sv) tag = si;
                else begin tag = 0; m_unf = 1; end
            end else begin
                tag = q.pop_front();
            end
            m1_d1 = d1; m1_d2 = d2;
            m1_s  = (tag > MAXS) ? MAXS : tag;
        end
        if (sv && !byp) begin
            if (q.size() < DEPTH) q.push_back(si);
            else m_ovf = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("dout_valid", 64'(dout_valid), 64'(m2_v));
        chk("dout1", 64'(dout1), 64'(e1));
        chk("dout2", 64'(dout2), 64'(e2));
        chk("dout_shift", 64'(dout_shift), 64'(es));
        chk("fifo_count", 64'(fifo_count), 64'(q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underflow", 64'(underflow), 64'(m_unf));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(dout_valid), 64'd0);
        chk({tag, "_dout1"}, 64'(dout1), 64'd0);
        chk({tag, "_dout2"}, 64'(dout2), 64'd0);
        chk({tag, "_shift"}, 64'(dout_shift), 64'd0);
        chk({tag, "_count"}, 64'(fifo_count), 64'd0);
        chk({tag, "_ovf"}, 64'(overflow), 64'd0);
        chk({tag, "_unf"}, 64'(underflow), 64'd0);
    endtask

    // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
    task automatic step(input bit sv, input int si, input bit dv,
                        input logic [31:0] d1, input logic [31:0] d2);
        shift_valid = sv; shift_in = SW'(si);
        din_valid = dv; din1 = d1; din2 = d2;
        @(posedge clk);
        model_update(sv, si, dv, d1, d2);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        shift_valid = 0; din_valid = 0;
        #2 rst_n = 1'b0;
        #1 check_zero(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pct_s, pct_d;
        rst_n = 1'b0;
        shift_valid = 0; shift_in = '0; din_valid = 0; din1 = '0; din2 = '0;
        model_reset();
        @(negedge clk);
        check_zero("por");
        rst_n = 1'b1;

        // Two tags popped back to back
        step(1, 3, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("t1_count", 64'(fifo_count), 64'd2);
        step(0, 0, 1, 32'h80, 32'h10);
        step(0, 0, 1, 32'h80, 32'h10);
        chk("t1_a_dout1", 64'(dout1), 64'h10);
        chk("t1_a_dout2", 64'(dout2), 64'h02);
        chk("t1_a_shift", 64'(dout_shift), 64'd3);
        idle();
        chk("t1_b_dout1", 64'(dout1), 64'h80);
        chk("t1_b_dout2", 64'(dout2), 64'h10);
        idle();
        chk("t1_drain_valid", 64'(dout_valid), 64'd0);

        // Clamp of an oversized tag
        step(1, 20, 0, 0, 0);
        step(0, 0, 1, 32'h0010_0000, 32'hffff_ffff);
        idle();
        chk("t2_dout1", 64'(dout1), 64'h400);
        chk("t2_shift", 64'(dout_shift), 64'd10);

        // Bypass on empty, then underflow
        do_reset("rst_t4");
        step(1, 2, 1, 32'd8, 32'd0);
        idle();
        chk("t4_byp_dout1", 64'(dout1), 64'd2);
        chk("t4_byp_unf", 64'(underflow), 64'd0);
        chk("t4_byp_count", 64'(fifo_count), 64'd0);
        step(0, 0, 1, 32'h1234_5678, 32'h9abc_def0);
        idle();
        chk("t4_unf_dout1", 64'(dout1), 64'h1234_5678);
        chk("t4_unf_shift", 64'(dout_shift), 64'd0);
        chk("t4_unf_flag", 64'(underflow), 64'd1);

        // Full FIFO with simultaneous push and pop
        do_reset("rst_t5");
        for (int i = 0; i < DEPTH; i++) step(1, i % 11, 0, 0, 0);
        chk("t5_full_ovf", 64'(overflow), 64'd0);
        step(1, 9, 1, 32'h200, 32'h400);
        chk("t5_count", 64'(fifo_count), 64'd16);
        chk("t5_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 32'h200, 32'h400);
        idle();
        chk("t5_tag_shift", 64'(dout_shift), 64'd9);
        chk("t5_tag_dout1", 64'(dout1), 64'd1);

        // Overflow: 17 pushes, then drain past empty
        do_reset("rst_t3");
        for (int i = 0; i < DEPTH + 1; i++) step(1, (i * 5) % 32, 0, 0, 0);
        chk("t3_count", 64'(fifo_count), 64'd16);
        chk("t3_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, $urandom, $urandom);
        idle(); idle();
        chk("t3_unf", 64'(underflow), 64'd1);

        // Rounding behaviour
        do_reset("rst_t6");
        step(1, 2, 0, 0, 0);
        step(0, 0, 1, 32'd6, 32'd5);
        idle();
`ifdef SHIFT_RESTORE_ROUND_EN
        chk("t6_round", 64'(dout1), 64'd2);
`else
        chk("t6_trunc", 64'(dout1), 64'd1);
`endif

        // Reset in the middle of traffic
        for (int i = 0; i < 4; i++) step(1, i + 1, 0, 0, 0);
        step(1, 7, 1, 32'hdead_beef, 32'h1234_5678);
        step(0, 0, 1, 32'hcafe_f00d, 32'h0bad_cafe);
        do_reset("rst_mid");
        idle(); idle(); idle();
        chk("mid_no_valid", 64'(dout_valid), 64'd0);
        chk("mid_count", 64'(fifo_count), 64'd0);

        // Randomized traffic in several load mixes
        for (int phase = 0; phase < 4; phase++) begin
            case (phase)
                0: begin pct_s = 70; pct_d = 30; end
                1: begin pct_s = 30; pct_d = 70; end
                2: begin pct_s = 50; pct_d = 50; end
                default: begin pct_s = 90; pct_d = 85; end
            endcase
            for (int i = 0; i < 150; i++)
                step($urandom_range(0, 99) < pct_s, $urandom_range(0, 31),
                     $urandom_range(0, 99) < pct_d, $urandom, $urandom);
            if (phase == 1) do_reset("rst_rand");
        end
        idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_restore.md
SHIFT_RESTORE -- requirements
Module: shift_restore

Interface
REQ-001 Parameter DIN_WIDTH, default 32: width of each data word.
REQ-002 Parameter SHIFT_WIDTH, default 5: width of a shift tag, equal to $clog2(DIN_WIDTH).
REQ-003 Parameter MAX_SHIFT, default 10: largest shift ever undone; larger tags are clamped.
REQ-004 Parameter FIFO_DEPTH, default 16, power of two: number of outstanding shift tags held.
REQ-005 clk  input  1: single clock; all logic on the rising edge.
REQ-006 rst_n  input  1: asynchronous, active-low reset.
REQ-007 shift_in  input  SHIFT_WIDTH: left-shift amount applied upstream to one sample pair.
REQ-008 shift_valid  input  1: push shift_in into the tag FIFO this cycle.
REQ-009 din1, din2  input  DIN_WIDTH each: unsigned processed data returning from the datapath.
REQ-010 din_valid  input  1: din1/din2 are valid; pops one tag.
REQ-011 dout1, dout2  output  DIN_WIDTH each: data right-shifted by the matched tag.
REQ-012 dout_shift  output  SHIFT_WIDTH: clamped tag used for the current dout pair.
REQ-013 dout_valid  output  1: dout1/dout2/dout_shift valid.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1: tags currently stored.
REQ-015 overflow, underflow  output  1 each: sticky error flags.

Function
REQ-016 Tags SHALL be stored in a circular FIFO with write/read pointers wrapping modulo FIFO_DEPTH.
REQ-017 A push SHALL occur on shift_valid when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-018 A push while full without a simultaneous pop SHALL be dropped and SHALL set overflow.
REQ-019 A pop SHALL occur on every din_valid; tags SHALL be consumed in push order.
REQ-020 With the FIFO empty and shift_valid and din_valid asserted together, the incoming shift_in SHALL be used directly (bypass), and fifo_count SHALL stay 0.
REQ-021 din_valid with the FIFO empty and no shift_valid SHALL use tag 0 and set underflow; dout_valid SHALL still assert.
REQ-022 fifo_count SHALL increase by 1 on push only, decrease by 1 on pop only, and remain unchanged on push+pop or bypass.
REQ-023 Pipeline stage 1 SHALL register din1, din2, the selected tag clamped to MAX_SHIFT, and din_valid.
REQ-024 Pipeline stage 2 SHALL register the logical right shifts of the stage-1 data by the clamped tag into dout1/dout2, plus the tag into dout_shift.
REQ-025 Latency SHALL be exactly 2 cycles from din_valid to dout_valid; back-to-back din_valid SHALL be accepted every cycle.
REQ-026 overflow and underflow SHALL remain set until reset.

Reset
REQ-027 While rst_n is low, pointers, fifo_count, pipeline valids, dout1, dout2, dout_shift, overflow and underflow SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all stored tags and in-flight samples; no dout_valid SHALL appear for them after release.
REQ-029 FIFO storage contents need no reset.

Configuration
REQ-030 With macro SHIFT_RESTORE_ROUND_EN defined, stage 2 SHALL add 2^(s-1) before a right shift by s (s>=1), rounding half up; s=0 passes data unchanged.
REQ-031 Without SHIFT_RESTORE_ROUND_EN, the shift SHALL truncate, and no rounding logic SHALL be present.
REQ-032 The rounding add SHALL be computed DIN_WIDTH+1 bits wide so that it cannot overflow.

Verification
REQ-033 Test 1: push tags 3, then 0; din1=0x00000080, din2=0x00000010 pops twice -> outputs 0x10/0x02, then 0x80/0x10, each 2 cycles after its pop.
REQ-034 Test 2: push tag 20 with MAX_SHIFT=10; din1=0x00100000 -> dout1=0x00000400, dout_shift=10.
REQ-035 Test 3: push 17 tags with no pops at depth 16 -> fifo_count=16 and overflow=1; the 17th tag is never output.
REQ-036 Test 4: din_valid with the FIFO empty -> dout equals din, dout_shift=0, underflow=1; simultaneous shift_in=2/din_valid on empty with din1=8 -> dout1=2, no underflow.
REQ-037 Test 5: full FIFO with simultaneous push+pop -> fifo_count stays 16, no overflow, and the pushed tag is output 16 pops later.
REQ-038 Test 6: with SHIFT_RESTORE_ROUND_EN, tag 2 and din1=6 -> dout1=2; without it -> dout1=1; reset pulse mid-stream -> all outputs 0 and fifo_count=0.
